// File: rtl/alu_pkg.sv
// Shared definitions for the integer execute units: MDU op codes, MDU FSM states
// and the op-decode helpers used by both the iterative core and its sign fix.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(input mdu_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 is treated as signed by every op except the fully unsigned ones
    function automatic logic is_signed1(input mdu_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed2(input mdu_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic returns_high(input mdu_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling around the unsigned iterative core: operand
// magnitudes on the way in, two's-complement result correction on the way out.
module mdu_sign_fix
    import alu_pkg::*;
#(
    parameter int INPUT_WIDTH = 32
) (
    input  mdu_op_e                      i_op,
    input  logic [INPUT_WIDTH-1:0]       i_op1,
    input  logic [INPUT_WIDTH-1:0]       i_op2,
    output logic                         o_sign1,
    output logic                         o_sign2,
    output logic [INPUT_WIDTH-1:0]       o_mag1,
    output logic [INPUT_WIDTH-1:0]       o_mag2,
    input  mdu_op_e                      i_res_op,
    input  logic                         i_res_sign1,
    input  logic                         i_res_sign2,
    input  logic [2*INPUT_WIDTH-1:0]     i_core,
    output logic [INPUT_WIDTH-1:0]       o_result
);
    localparam int W = INPUT_WIDTH;

    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quot;
    logic [W-1:0]   w_rem;
    logic           w_neg;

    // Most-negative maps onto itself, which read as unsigned is the true magnitude
    assign o_sign1 = i_op1[W-1] & is_signed1(i_op);
    assign o_sign2 = i_op2[W-1] & is_signed2(i_op);
    assign o_mag1  = o_sign1 ? (~i_op1 + 1'b1) : i_op1;
    assign o_mag2  = o_sign2 ? (~i_op2 + 1'b1) : i_op2;

    assign w_neg  = i_res_sign1 ^ i_res_sign2;
    assign w_prod = w_neg ? (~i_core + 1'b1) : i_core;
    assign w_quot = i_core[W-1:0];
    assign w_rem  = i_core[2*W-1:W];

    always_comb begin
        o_result = '0;
        if (!is_div(i_res_op)) begin
            o_result = returns_high(i_res_op) ? w_prod[2*W-1:W] : w_prod[W-1:0];
        end else if (is_rem(i_res_op)) begin
            o_result = i_res_sign1 ? (~w_rem + 1'b1) : w_rem;
        end else begin
            o_result = w_neg ? (~w_quot + 1'b1) : w_quot;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on magnitudes, with a start/busy/done handshake.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int INPUT_WIDTH   = 32,
    parameter int CONTROL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CONTROL_WIDTH-1:0] MDUctrl,
    input  logic [INPUT_WIDTH-1:0]   MDUop1,
    input  logic [INPUT_WIDTH-1:0]   MDUop2,
    output logic                     busy,
    output logic                     done,
    output logic [INPUT_WIDTH-1:0]   MDUout
);
    localparam int W     = INPUT_WIDTH;
    localparam int CNT_W = $clog2(INPUT_WIDTH + 1);

    mdu_state_e       r_state, w_state_nxt;
    mdu_op_e          r_op;
    logic             r_sign1, r_sign2, r_fast;
    logic [W-1:0]     r_addend, r_fast_res, r_out;
    logic [2*W:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;

    mdu_op_e          w_op;
    logic             w_sign1, w_sign2;
    logic [W-1:0]     w_mag1, w_mag2, w_result, w_fast_res;
    logic             w_div0, w_ovf, w_fast, w_accept, w_calc_end;
    logic [W:0]       w_sum, w_trial;
    logic [2*W:0]     w_mul_nxt, w_shl, w_div_nxt;

    assign w_op = mdu_op_e'(MDUctrl[2:0]);

    mdu_sign_fix #(.INPUT_WIDTH(W)) u_sign_fix (
        .i_op        (w_op),
        .i_op1       (MDUop1),
        .i_op2       (MDUop2),
        .o_sign1     (w_sign1),
        .o_sign2     (w_sign2),
        .o_mag1      (w_mag1),
        .o_mag2      (w_mag2),
        .i_res_op    (r_op),
        .i_res_sign1 (r_sign1),
        .i_res_sign2 (r_sign2),
        .i_core      (r_acc[2*W-1:0]),
        .o_result    (w_result)
    );

    // Special divide cases are resolved at accept and never iterate
    assign w_div0 = (MDUop2 == '0);
    assign w_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                    (MDUop1 == {1'b1, {(W-1){1'b0}}}) && (MDUop2 == '1);
    assign w_fast = is_div(w_op) && (w_div0 || w_ovf);

    always_comb begin
        if (!is_rem(w_op)) w_fast_res = w_div0 ? '1 : MDUop1;
        else               w_fast_res = w_div0 ? MDUop1 : '0;
    end

    assign w_accept   = (r_state == IDLE) && start;
    assign w_calc_end = r_fast || (r_cnt == CNT_W'(W));

    // Multiply: low half holds the multiplier, high half accumulates, shift right
    assign w_sum     = r_acc[2*W:W] + {1'b0, (r_acc[0] ? r_addend : {W{1'b0}})};
    assign w_mul_nxt = {1'b0, w_sum, r_acc[W-1:1]};

    // Divide: shift left, trial-subtract divisor from the partial remainder
    assign w_shl     = {r_acc[2*W-1:0], 1'b0};
    assign w_trial   = w_shl[2*W:W] - {1'b0, r_addend};
    assign w_div_nxt = w_trial[W] ? w_shl : {w_trial, w_shl[W-1:1], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (w_calc_end) w_state_nxt = DONE;
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= OP_MUL;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_fast     <= 1'b0;
            r_addend   <= '0;
            r_fast_res <= '0;
            r_out      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_op       <= w_op;
            r_sign1    <= w_sign1;
            r_sign2    <= w_sign2;
            r_fast     <= w_fast;
            r_fast_res <= w_fast_res;
            r_cnt      <= '0;
            if (is_div(w_op)) begin
                r_acc    <= {{(W+1){1'b0}}, w_mag1};
                r_addend <= w_mag2;
            end else begin
                r_acc    <= {{(W+1){1'b0}}, w_mag2};
                r_addend <= w_mag1;
            end
        end else if (r_state == CALC) begin
            if (w_calc_end) begin
                r_out <= r_fast ? r_fast_res : w_result;
            end else begin
                r_acc <= is_div(r_op) ? w_div_nxt : w_mul_nxt;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign MDUout = r_out;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed RV32M cases, random ops, start-while-busy,
// back-to-back throughput and mid-operation reset, checked through a result scoreboard.
module tb_alu_mdu;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    MDUctrl = '0;
    logic [W-1:0]  MDUop1 = '0;
    logic [W-1:0]  MDUop2 = '0;
    logic          busy, done;
    logic [W-1:0]  MDUout;

    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    logic [W-1:0]  sb_q[$];

    alu_mdu #(.INPUT_WIDTH(W), .CONTROL_WIDTH(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .MDUctrl (MDUctrl),
        .MDUop1  (MDUop1),
        .MDUop2  (MDUop2),
        .busy    (busy),
        .done    (done),
        .MDUout  (MDUout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint la, lb, p;
        longint unsigned ua, ub, up;
        la = $signed(a);
        lb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = la * lb; return p[31:0]; end
            3'd1: begin p = la * lb; return p[63:32]; end
            3'd2: begin p = la * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = la / lb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = la % lb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return W + 1;
    endfunction

    // Scoreboard: every done pops one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) chk("spurious_done", {63'd0, done}, 64'd0);
            else                  chk("result", {32'd0, MDUout}, {32'd0, sb_q.pop_front()});
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit interfere, output int acc_cyc);
        int  lat;
        bit  busy_ok;
        lat = 0;
        @(negedge clk);
        while ((busy || done) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) chk("idle_timeout", {63'd0, busy}, 64'd0);
        MDUctrl = op; MDUop1 = a; MDUop2 = b; start = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        sb_q.push_back(model(op, a, b));
        @(negedge clk);
        start = 1'b0;
        MDUctrl = 3'($urandom); MDUop1 = $urandom; MDUop2 = $urandom;
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            busy_ok &= busy;
            if (interfere && lat == 5) begin
                start = 1'b1; MDUctrl = 3'd0; MDUop1 = 32'd11; MDUop2 = 32'd13;
            end
            if (interfere && lat == 6) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        busy_ok &= busy;
        chk("latency", 64'(lat), 64'(exp_lat(op, a, b)));
        chk("busy_held", {63'd0, busy_ok}, 64'd1);
    endtask

    logic [2:0]  d_op[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a[12]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b[12]  = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] edge_v[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, nd;
        logic [31:0] ra, rb;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_out", {32'd0, MDUout}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) issue(d_op[i], d_a[i], d_b[i], 1'b0, t0);

        issue(3'd5, 32'd1000, 32'd3, 1'b1, t0);
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, t0);

        issue(3'd0, 32'd12, 32'd12, 1'b0, t0);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, t1);
        chk("b2b_gap", 64'(t1 - t0), 64'(W + 3));

        for (int i = 0; i < 24; i++) begin
            ra = (i % 3 == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            rb = (i % 4 == 1) ? edge_v[$urandom_range(0, 3)] : $urandom;
            if (i % 5 == 2) rb = {28'd0, 4'($urandom)};
            issue(3'($urandom), ra, rb, 1'b0, t0);
        end

        // Reset in the middle of a divide: outputs clear at once, no done follows
        @(negedge clk);
        MDUctrl = 3'd4; MDUop1 = 32'd987_654_321; MDUop2 = 32'd37; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_out", {32'd0, MDUout}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_rst", 64'(nd), 64'd0);

        issue(3'd0, 32'd3, 32'd3, 1'b0, t0);
        chk("post_rst_out", {32'd0, MDUout}, 64'd9);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
